bus_conv_16to_48: RTL and testbench

//  Packs a 16-bit packet stream (sop/eop/vld) into 48-bit words, 3 lanes per word, MSB lane first.

---
 rtl/bus_conv_16to_48_pkg.sv | 31 +++
 rtl/bus_conv_16to_48.sv | 112 +++++++++++
 tb/tb_bus_conv_16to_48.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_conv_16to_48_pkg.sv
// Shared widths, FSM encoding and a lane-placement helper
// for the 16-to-48 bit packet packer.
package bus_conv_16to_48_pkg;

    localparam int DIN_W  = 16;
    localparam int LANES  = 3;
    localparam int DOUT_W = DIN_W * LANES;
    localparam int MTY_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    // Lane 0 occupies the most significant 16 bits of the word.
    function automatic logic [DOUT_W-1:0] placeLane(
        input logic [DOUT_W-1:0] base,
        input logic [DIN_W-1:0]  lane,
        input logic [1:0]        idx
    );
        logic [DOUT_W-1:0] word;
        word = base;
        for (int i = 0; i < LANES; i++) begin
            if (idx == 2'(i)) begin
                word[DOUT_W-1-i*DIN_W -: DIN_W] = lane;
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/bus_conv_16to_48.sv
// Packs a 16-bit sop/eop/vld stream into 48-bit words (three lanes, MSB lane
// first) behind a single registered output stage with backpressure.
module bus_conv_16to_48
    import bus_conv_16to_48_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic              din_rdy,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [MTY_W-1:0]  dout_mty,
    input  logic              b_rdy,
    output logic              err
);

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic [DOUT_W-1:0]   r_acc;
    logic                r_sopPend;
    logic                r_rdyEn;
    logic [DOUT_W-1:0]   r_dout;
    logic                r_doutVld;
    logic                r_doutSop;
    logic                r_doutEop;
    logic [MTY_W-1:0]    r_doutMty;
    logic                r_err;

    logic                w_accept;
    logic                w_startPkt;
    logic                w_useBeat;
    logic                w_complete;
    logic                w_err;
    logic                w_wordSop;
    logic [1:0]          w_laneIdx;
    logic [DOUT_W-1:0]   w_base;
    logic [DOUT_W-1:0]   w_word;

    // r_rdyEn keeps din_rdy low while reset is applied and for the first edge after it.
    assign din_rdy  = r_rdyEn && (!r_doutVld || b_rdy);
    assign dout     = r_dout;
    assign dout_vld = r_doutVld;
    assign dout_sop = r_doutSop;
    assign dout_eop = r_doutEop;
    assign dout_mty = r_doutMty;
    assign err      = r_err;

    always_comb begin
        w_accept   = din_vld && din_rdy;
        w_startPkt = w_accept && din_sop;
        w_useBeat  = w_accept && (din_sop || r_state == PKT);
        w_err      = w_accept && (din_sop ? (r_state == PKT) : (r_state == IDLE));
        w_laneIdx  = w_startPkt ? 2'd0 : r_cnt;
        w_base     = w_startPkt ? '0 : r_acc;
        w_word     = placeLane(w_base, din, w_laneIdx);
        w_complete = w_useBeat && (w_laneIdx == 2'(LANES - 1) || din_eop);
        w_wordSop  = din_sop || r_sopPend;
    end

    // A sop in PKT simply restarts from lane 0, which discards the partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_sopPend <= 1'b0;
            r_rdyEn   <= 1'b0;
            r_dout    <= '0;
            r_doutVld <= 1'b0;
            r_doutSop <= 1'b0;
            r_doutEop <= 1'b0;
            r_doutMty <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rdyEn <= 1'b1;
            r_err   <= w_err;

            if (w_useBeat) begin
                if (w_complete) begin
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_sopPend <= 1'b0;
                    r_state   <= din_eop ? IDLE : PKT;
                end else begin
                    r_acc     <= w_word;
                    r_cnt     <= w_laneIdx + 2'd1;
                    r_sopPend <= w_wordSop;
                    r_state   <= PKT;
                end
            end

            if (w_complete) begin
                r_dout    <= w_word;
                r_doutVld <= 1'b1;
                r_doutSop <= w_wordSop;
                r_doutEop <= din_eop;
                r_doutMty <= din_eop ? (MTY_W'(LANES - 1) - MTY_W'(w_laneIdx)) : '0;
            end else if (b_rdy) begin
                r_doutVld <= 1'b0;
                r_doutSop <= 1'b0;
                r_doutEop <= 1'b0;
                r_doutMty <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_conv_16to_48.sv
// Scoreboard bench for bus_conv_16to_48: a lane-list reference model queues
// expected words, and an independent monitor checks what the DUT presents.
module tb_bus_conv_16to_48;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        din_vld;
    logic        din_sop;
    logic        din_eop;
    logic        din_rdy;
    logic [47:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic [2:0]  dout_mty;
    logic        b_rdy;
    logic        err;

    bus_conv_16to_48 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_mty (dout_mty),
        .b_rdy    (b_rdy),
        .err      (err)
    );

    typedef struct {
        logic [47:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mty;
        int          tag;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] laneQ[$];
    logic        inPkt;
    logic        firstWord;
    logic        expErrNext;
    logic        take;
    exp_t        newExp;
    exp_t        curExp;
    int          cyc;
    logic        lastVld;
    logic        lastBrdy;
    logic        fresh;
    logic [47:0] heldData;
    logic [4:0]  heldFlags;
    int          errors;
    int          checks;
    logic        randDone;
    logic        drvInPkt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: collects accepted lanes per packet and emits a word
    // whenever three lanes are gathered or the packet ends.
    always begin
        @(negedge clk);
        #2;
        expErrNext = 1'b0;
        if (rst_n && din_vld && din_rdy) begin
            take = 1'b1;
            if (din_sop) begin
                if (inPkt) expErrNext = 1'b1;
                laneQ.delete();
                inPkt     = 1'b1;
                firstWord = 1'b1;
            end else if (!inPkt) begin
                expErrNext = 1'b1;
                take       = 1'b0;
            end
            if (take) begin
                laneQ.push_back(din);
                if (din_eop || laneQ.size() == 3) begin
                    newExp.data = '0;
                    for (int i = 0; i < laneQ.size(); i++) begin
                        newExp.data = newExp.data | (48'(laneQ[i]) << (16 * (2 - i)));
                    end
                    newExp.sop = firstWord;
                    newExp.eop = din_eop;
                    newExp.mty = din_eop ? 3'(3 - laneQ.size()) : 3'd0;
                    newExp.tag = cyc + 1;
                    expQ.push_back(newExp);
                    laneQ.delete();
                    firstWord = 1'b0;
                    if (din_eop) inPkt = 1'b0;
                end
            end
        end
    end

    // Monitor: pops an expectation whenever a freshly loaded word appears.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            lastVld  = 1'b0;
            lastBrdy = 1'b0;
        end else begin
            fresh = !lastVld || lastBrdy;
            if (dout_vld && fresh) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got %0h, expected no word (t=%0t)", dout, $time);
                end else begin
                    curExp = expQ.pop_front();
                    checkOutput("dout", 64'(dout), 64'(curExp.data));
                    checkOutput("dout_sop", 64'(dout_sop), 64'(curExp.sop));
                    checkOutput("dout_eop", 64'(dout_eop), 64'(curExp.eop));
                    checkOutput("dout_mty", 64'(dout_mty), 64'(curExp.mty));
                    checkOutput("latency_cycle", 64'(cyc), 64'(curExp.tag));
                end
                heldData  = dout;
                heldFlags = {dout_sop, dout_eop, dout_mty};
            end else if (dout_vld) begin
                checkOutput("hold_dout", 64'(dout), 64'(heldData));
                checkOutput("hold_flags", 64'({dout_sop, dout_eop, dout_mty}), 64'(heldFlags));
            end else begin
                checkOutput("idle_flags", 64'({dout_sop, dout_eop, dout_mty}), 64'd0);
            end
            checkOutput("err", 64'(err), 64'(expErrNext));
            if (dout_vld) checkOutput("din_rdy_bp", 64'(din_rdy), 64'(b_rdy));
            lastVld  = dout_vld;
            lastBrdy = b_rdy;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one beat and holds it until accepted; called at posedge+1.
    task automatic applyStimulus(input logic [15:0] d, input logic s, input logic e, output int waits);
        logic acc;
        din     = d;
        din_sop = s;
        din_eop = e;
        din_vld = 1'b1;
        waits   = 0;
        forever begin
            @(negedge clk);
            acc = din_rdy;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: beat %0h not accepted after %0d cycles", d, waits);
                break;
            end
        end
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_din_rdy", 64'(din_rdy), 64'd0);
        checkOutput("rst_dout", 64'(dout), 64'd0);
        checkOutput("rst_flags", 64'({dout_vld, dout_sop, dout_eop, dout_mty, err}), 64'd0);
        expQ.delete();
        laneQ.delete();
        inPkt      = 1'b0;
        firstWord  = 1'b0;
        expErrNext = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        errors = 0; checks = 0; cyc = 0;
        inPkt = 1'b0; firstWord = 1'b0; expErrNext = 1'b0;
        lastVld = 1'b0; lastBrdy = 1'b0;
        heldData = '0; heldFlags = '0;
        randDone = 1'b0; drvInPkt = 1'b0;
        din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; b_rdy = 1'b0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_din_rdy", 64'(din_rdy), 64'd0);
        checkOutput("rst_flags", 64'({dout_vld, dout_sop, dout_eop, dout_mty, err}), 64'd0);
        idle(3);
        rst_n = 1'b1;
        b_rdy = 1'b1;
        idle(2);

        $display("[TB] six-beat packet");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(16'(i * 16'h1111), i == 1, i == 6, w);
            checkOutput("no_bubble_6beat", 64'(w), 64'd0);
        end
        idle(2);

        $display("[TB] four-beat packet and single beat");
        for (int i = 1; i <= 4; i++) applyStimulus(16'hA000 + 16'(i), i == 1, i == 4, w);
        applyStimulus(16'hBEEF, 1'b1, 1'b1, w);
        idle(2);

        $display("[TB] backpressure");
        b_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) applyStimulus(16'hC000 + 16'(i), i == 1, 1'b0, w);
        fork
            begin
                for (int i = 4; i <= 6; i++) applyStimulus(16'hC000 + 16'(i), 1'b0, i == 6, w);
            end
            begin
                idle(5);
                b_rdy = 1'b1;
            end
        join
        idle(2);

        $display("[TB] continuous stream");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(16'h5000 + 16'(i), i == 0, i == 8, w);
            checkOutput("no_bubble_stream", 64'(w), 64'd0);
        end
        idle(2);

        $display("[TB] protocol errors");
        applyStimulus(16'hD001, 1'b1, 1'b0, w);
        applyStimulus(16'hD002, 1'b0, 1'b0, w);
        applyStimulus(16'hE001, 1'b1, 1'b0, w);
        applyStimulus(16'hE002, 1'b0, 1'b0, w);
        applyStimulus(16'hE003, 1'b0, 1'b1, w);
        idle(1);
        applyStimulus(16'hF000, 1'b0, 1'b0, w);
        idle(2);

        $display("[TB] reset mid-word");
        for (int i = 1; i <= 4; i++) applyStimulus(16'h7000 + 16'(i), i == 1, 1'b0, w);
        doReset();
        applyStimulus(16'h8001, 1'b1, 1'b0, w);
        applyStimulus(16'h8002, 1'b0, 1'b1, w);
        idle(2);

        $display("[TB] random traffic");
        fork
            begin
                while (!randDone) begin
                    @(posedge clk);
                    #1;
                    b_rdy = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    logic s, e;
                    if ($urandom_range(0, 4) == 0) idle(1);
                    s = drvInPkt ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 19) != 0);
                    e = ($urandom_range(0, 2) == 0);
                    applyStimulus(16'($urandom), s, e, w);
                    if (s || drvInPkt) drvInPkt = !e;
                end
                randDone = 1'b1;
            end
        join

        b_rdy = 1'b1;
        idle(10);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
